vc_chan_queue: RTL and testbench

- Multi-channel message queue: p_num_chans independent FIFOs share one enqueue port and one dequeue port.
- Enqueue carries an explicit channel id. Dequeue is arbitrated round-robin among non-empty channels, and the winning channel id is returned with the message.
- Adds per-channel almost-full status, per-channel flush, and an optional pipe mode.
- Used as the virtual-channel buffer in front of cache-coherence message ports, so one request class cannot block another.

---
 rtl/vc_chan_queue_pkg.sv | 13 +
 rtl/vc_rr_arb.sv | 60 ++++++
 rtl/vc_chan_queue.sv | 149 ++++++++++++++
 tb/tb_vc_chan_queue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_chan_queue_pkg.sv
// Shared queue-type encodings and small helpers for the virtual-channel queue.
package vc_chan_queue_pkg;

    localparam logic [3:0] VC_QUEUE_NORMAL = 4'b0000;
    localparam logic [3:0] VC_QUEUE_PIPE   = 4'b0001;
    localparam logic [3:0] VC_QUEUE_BYPASS = 4'b0010;

    // Increment modulo n; works for non-power-of-2 ring sizes.
    function automatic int wrap_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/vc_rr_arb.sv
// Round-robin arbiter with an internal priority pointer. The grant is locked
// while a presented request is not consumed, so newly arriving requests with
// higher round-robin priority cannot steal a stalled grant.
module vc_rr_arb
    import vc_chan_queue_pkg::*;
#(
    parameter int p_num_reqs = 4,
    localparam int c_idx_nbits = $clog2(p_num_reqs)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [p_num_reqs-1:0]  reqs,
    input  logic                   advance,
    output logic [p_num_reqs-1:0]  grant,
    output logic [c_idx_nbits-1:0] grant_idx
);

    logic [c_idx_nbits-1:0] ptr;
    logic                   lock_val;
    logic [c_idx_nbits-1:0] lock_idx;
    logic                   found;
    int                     scan;

    // Pick the held grant if still requesting, else first request at/after ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan      = 0;
        if (lock_val && reqs[lock_idx]) begin
            grant[lock_idx] = 1'b1;
            grant_idx       = lock_idx;
        end else begin
            for (int i = 0; i < p_num_reqs; i++) begin
                scan = int'(ptr) + i;
                if (scan >= p_num_reqs) scan = scan - p_num_reqs;
                if (!found && reqs[scan]) begin
                    found       = 1'b1;
                    grant[scan] = 1'b1;
                    grant_idx   = c_idx_nbits'(scan);
                end
            end
        end
    end

    // Pointer moves past the winner only on a consumed grant; lock otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            lock_val <= 1'b0;
            lock_idx <= '0;
        end else begin
            if (advance && (|reqs))
                ptr <= c_idx_nbits'(wrap_inc(int'(grant_idx), p_num_reqs));
            lock_val <= (|reqs) && !advance;
            lock_idx <= grant_idx;
        end
    end

endmodule

// File: rtl/vc_chan_queue.sv
// Multi-channel message queue: independent per-channel FIFOs sharing one
// enqueue port and one round-robin arbitrated dequeue port, with per-channel
// flush, occupancy and almost-full status, and optional pipe mode.
module vc_chan_queue
    import vc_chan_queue_pkg::*;
#(
    parameter logic [3:0] p_type         = VC_QUEUE_NORMAL,
    parameter int         p_msg_nbits    = 32,
    parameter int         p_num_chans    = 4,
    parameter int         p_num_msgs     = 4,
    parameter int         p_afull_thresh = 1,
    localparam int        c_chan_nbits   = $clog2(p_num_chans),
    localparam int        c_addr_nbits   = $clog2(p_num_msgs)
)(
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     enq_val,
    output logic                                     enq_rdy,
    input  logic [c_chan_nbits-1:0]                  enq_chan,
    input  logic [p_msg_nbits-1:0]                   enq_msg,
    output logic                                     deq_val,
    input  logic                                     deq_rdy,
    output logic [c_chan_nbits-1:0]                  deq_chan,
    output logic [p_msg_nbits-1:0]                   deq_msg,
    input  logic [p_num_chans-1:0]                   flush,
    output logic [p_num_chans-1:0]                   chan_full,
    output logic [p_num_chans-1:0]                   almost_full,
    output logic [p_num_chans*(c_addr_nbits+1)-1:0]  chan_count
);

    localparam int c_cnt_nbits = c_addr_nbits + 1;
    localparam int c_depth     = p_num_chans * p_num_msgs;
    localparam int c_mem_nbits = $clog2(c_depth);
    localparam bit c_pipe      = (p_type & VC_QUEUE_PIPE) != 4'b0000;

    if ((p_type & VC_QUEUE_BYPASS) != 4'b0000) begin : g_bypass_unsupported
        $error("vc_chan_queue: bypass mode is not supported");
    end
    if (p_num_chans < 2 || p_num_msgs < 2) begin : g_size_unsupported
        $error("vc_chan_queue: needs at least 2 channels and 2 entries per channel");
    end

    logic [c_cnt_nbits-1:0]  count   [p_num_chans];
    logic [c_addr_nbits-1:0] enq_ptr [p_num_chans];
    logic [c_addr_nbits-1:0] deq_ptr [p_num_chans];
    logic [p_num_chans-1:0]  eligible;
    logic [p_num_chans-1:0]  grant_oh;
    logic [c_chan_nbits-1:0] grant_idx;
    logic [c_chan_nbits-1:0] enq_idx;
    logic                    chan_ok;
    logic                    enq_fire;
    logic                    deq_fire;
    logic [p_msg_nbits-1:0]  mem [c_depth];
    logic [c_mem_nbits-1:0]  waddr;
    logic [c_mem_nbits-1:0]  raddr;

    function automatic logic [c_addr_nbits-1:0] ptr_inc(input logic [c_addr_nbits-1:0] p);
        return c_addr_nbits'(wrap_inc(int'(p), p_num_msgs));
    endfunction

    vc_rr_arb #(
        .p_num_reqs (p_num_chans)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .reqs      (eligible),
        .advance   (deq_fire),
        .grant     (grant_oh),
        .grant_idx (grant_idx)
    );

    assign deq_val  = |eligible;
    assign deq_fire = deq_val && deq_rdy;
    assign deq_chan = grant_idx;
    assign enq_fire = enq_val && enq_rdy;

    // Enqueue acceptance; out-of-range ids are refused and never index state.
    always_comb begin
        chan_ok = 32'(enq_chan) < 32'(p_num_chans);
        enq_idx = chan_ok ? enq_chan : '0;
        enq_rdy = 1'b0;
        if (chan_ok && !flush[enq_idx]) begin
            if (count[enq_idx] < c_cnt_nbits'(p_num_msgs))
                enq_rdy = 1'b1;
            else if (c_pipe && deq_fire && (grant_idx == enq_idx))
                enq_rdy = 1'b1;
        end
    end

    // Flat storage addressing: each channel owns a contiguous p_num_msgs slice.
    always_comb begin
        waddr = c_mem_nbits'(int'(enq_idx) * p_num_msgs + int'(enq_ptr[enq_idx]));
        raddr = c_mem_nbits'(int'(grant_idx) * p_num_msgs + int'(deq_ptr[grant_idx]));
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[waddr] <= enq_msg;
    end

    assign deq_msg = mem[raddr];

    for (genvar c = 0; c < p_num_chans; c++) begin : g_chan
        logic [c_cnt_nbits-1:0]  count_q;
        logic [c_addr_nbits-1:0] enq_ptr_q;
        logic [c_addr_nbits-1:0] deq_ptr_q;
        logic                    do_enq;
        logic                    do_deq;

        assign do_enq = enq_fire && (enq_idx == c_chan_nbits'(c));
        assign do_deq = deq_fire && grant_oh[c];

        // Pointer/count update; flush wins over any same-cycle operation.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count_q   <= '0;
                enq_ptr_q <= '0;
                deq_ptr_q <= '0;
            end else if (flush[c]) begin
                count_q   <= '0;
                enq_ptr_q <= '0;
                deq_ptr_q <= '0;
            end else begin
                if (do_enq) enq_ptr_q <= ptr_inc(enq_ptr_q);
                if (do_deq) deq_ptr_q <= ptr_inc(deq_ptr_q);
                if (do_enq && !do_deq)
                    count_q <= count_q + 1'b1;
                else if (!do_enq && do_deq)
                    count_q <= count_q - 1'b1;
            end
        end

        assign count[c]    = count_q;
        assign enq_ptr[c]  = enq_ptr_q;
        assign deq_ptr[c]  = deq_ptr_q;
        assign eligible[c] = (count_q != '0) && !flush[c];

        assign chan_full[c]   = count_q == c_cnt_nbits'(p_num_msgs);
        assign almost_full[c] = (p_num_msgs - int'(count_q)) <= p_afull_thresh;
        assign chan_count[c*c_cnt_nbits +: c_cnt_nbits] = count_q;

        a_count_bound: assert property (@(posedge clk) disable iff (!reset)
            count_q <= c_cnt_nbits'(p_num_msgs));
    end

    a_inputs_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({enq_val, deq_rdy, flush}));

endmodule

// File: tb/tb_vc_chan_queue.sv
// Scoreboard bench for vc_chan_queue: per-channel queue reference model,
// directed scenarios followed by randomized traffic.
module tb_vc_chan_queue;
    import vc_chan_queue_pkg::*;

    localparam int NCH = 4;
    localparam int D   = 4;
    localparam int AFT = 1;
    localparam int CW  = 3;
    localparam bit PIPE = 1'b1;

    logic        clk;
    logic        reset;
    logic        enq_val, enq_rdy, deq_val, deq_rdy;
    logic [1:0]  enq_chan, deq_chan;
    logic [31:0] enq_msg, deq_msg;
    logic [3:0]  flush, chan_full, almost_full;
    logic [11:0] chan_count;

    logic        n_enq_val, n_enq_rdy, n_deq_val, n_deq_rdy;
    logic [1:0]  n_enq_chan, n_deq_chan;
    logic [31:0] n_enq_msg, n_deq_msg;
    logic [3:0]  n_flush, n_chan_full, n_almost_full;
    logic [11:0] n_chan_count;

    vc_chan_queue #(.p_type(VC_QUEUE_PIPE), .p_msg_nbits(32), .p_num_chans(NCH),
                    .p_num_msgs(D), .p_afull_thresh(AFT)) dut (
        .clk(clk), .reset(reset),
        .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_chan(enq_chan), .enq_msg(enq_msg),
        .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_chan(deq_chan), .deq_msg(deq_msg),
        .flush(flush), .chan_full(chan_full), .almost_full(almost_full),
        .chan_count(chan_count));

    vc_chan_queue #(.p_type(VC_QUEUE_NORMAL), .p_msg_nbits(32), .p_num_chans(NCH),
                    .p_num_msgs(D), .p_afull_thresh(AFT)) dut_n (
        .clk(clk), .reset(reset),
        .enq_val(n_enq_val), .enq_rdy(n_enq_rdy), .enq_chan(n_enq_chan), .enq_msg(n_enq_msg),
        .deq_val(n_deq_val), .deq_rdy(n_deq_rdy), .deq_chan(n_deq_chan), .deq_msg(n_deq_msg),
        .flush(n_flush), .chan_full(n_chan_full), .almost_full(n_almost_full),
        .chan_count(n_chan_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          chan;
        logic [31:0] msg;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mq [NCH][$];
    int          rr_ptr;
    bit          held;
    int          hold_chan;
    exp_t        expq [$];
    exp_t        mon_e;
    logic [31:0] obs [$];
    logic        act_enq_rdy;
    logic        act_deq_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [2:0] cnt_of(input int c);
        return chan_count[c*CW +: CW];
    endfunction

    // One clock of stimulus: drive, compare against the model, advance the model.
    task automatic cycle(input bit ev, input int ec, input logic [31:0] em,
                         input bit dr, input logic [3:0] fl);
        int  gnt;
        int  j;
        bit  e_rdy, dfire, efire;
        @(negedge clk);
        enq_val  = ev;
        enq_chan = ec[1:0];
        enq_msg  = em;
        deq_rdy  = dr;
        flush    = fl;
        #1;
        act_enq_rdy = enq_rdy;
        act_deq_val = deq_val;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("count_c%0d", c), cnt_of(c), mq[c].size());
            chk($sformatf("full_c%0d", c), chan_full[c], mq[c].size() == D);
            chk($sformatf("afull_c%0d", c), almost_full[c], (D - mq[c].size()) <= AFT);
        end
        gnt = -1;
        if (held && mq[hold_chan].size() != 0 && !fl[hold_chan]) gnt = hold_chan;
        else begin
            for (int i = 0; i < NCH; i++) begin
                j = (rr_ptr + i) % NCH;
                if (gnt < 0 && mq[j].size() != 0 && !fl[j]) gnt = j;
            end
        end
        chk("deq_val", deq_val, gnt >= 0);
        if (gnt >= 0) begin
            chk("deq_chan", deq_chan, gnt);
            chk("deq_msg", deq_msg, mq[gnt][0]);
        end
        dfire = (gnt >= 0) && dr;
        e_rdy = !fl[ec] && (mq[ec].size() < D || (PIPE && dfire && gnt == ec));
        chk("enq_rdy", enq_rdy, e_rdy);
        efire = ev && e_rdy;
        if (dfire) expq.push_back('{chan: gnt, msg: mq[gnt][0]});
        held      = (gnt >= 0) && !dr;
        hold_chan = gnt;
        if (dfire) begin
            void'(mq[gnt].pop_front());
            rr_ptr = (gnt + 1) % NCH;
        end
        if (efire) mq[ec].push_back(em);
        for (int c = 0; c < NCH; c++) if (fl[c]) mq[c].delete();
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        reset   = 1'b0;
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        flush   = 4'b0;
        for (int c = 0; c < NCH; c++) mq[c].delete();
        rr_ptr = 0;
        held   = 1'b0;
        #1;
        chk("reset_deq_val", deq_val, 0);
        chk("reset_chan_count", chan_count, 0);
        chk("reset_chan_full", chan_full, 0);
        chk("reset_almost_full", almost_full, 0);
        repeat (ncyc) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_obs(input string name, input logic [31:0] want [$]);
        chk({name, "_len"}, obs.size(), want.size());
        for (int i = 0; i < want.size() && i < obs.size(); i++)
            chk($sformatf("%s_%0d", name, i), obs[i], want[i]);
    endtask

    // Monitor: every completed dequeue is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b1 && deq_val === 1'b1 && deq_rdy === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deq_unexpected actual chan=%0d msg=%0h required no dequeue",
                             deq_chan, deq_msg);
                end else begin
                    mon_e = expq.pop_front();
                    chk("sb_deq_chan", deq_chan, mon_e.chan);
                    chk("sb_deq_msg", deq_msg, mon_e.msg);
                end
                obs.push_back(deq_msg);
            end
        end
    end

    initial begin
        logic [3:0] fl;
        reset = 1'b0;
        enq_val = 0; enq_chan = 0; enq_msg = 0; deq_rdy = 0; flush = 0;
        n_enq_val = 0; n_enq_chan = 0; n_enq_msg = 0; n_deq_rdy = 0; n_flush = 0;
        rr_ptr = 0; held = 0; hold_chan = 0;
        do_reset(2);

        // Idle after reset: every channel accepts
        for (int c = 0; c < NCH; c++) begin
            cycle(0, c, 0, 0, 4'b0);
            chk($sformatf("idle_enq_rdy_c%0d", c), act_enq_rdy, 1);
        end

        // NORMAL instance: full granted channel refuses enqueue even with deq_rdy
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            n_enq_val = 1; n_enq_chan = 1; n_enq_msg = 32'h60 + i;
        end
        @(negedge clk);
        n_deq_rdy = 1; n_enq_msg = 32'h55;
        #1;
        chk("normal_full", n_chan_full[1], 1);
        chk("normal_enq_rdy", n_enq_rdy, 0);
        chk("normal_deq_chan", n_deq_chan, 1);
        chk("normal_deq_msg", n_deq_msg, 32'h60);
        @(negedge clk);
        n_enq_val = 0; n_deq_rdy = 0;
        #1;
        chk("normal_count", n_chan_count[5:3], 3);

        // Fill chan 2 then drain
        for (int i = 0; i < D; i++) begin
            cycle(1, 2, 32'hA0 + i, 0, 4'b0);
            chk("fill2_enq_rdy", act_enq_rdy, 1);
        end
        chk("afull2_after3", almost_full[2], 1);
        chk("full2_after3", chan_full[2], 0);
        cycle(1, 2, 32'hEE, 0, 4'b0);
        chk("full2_enq_rdy", act_enq_rdy, 0);
        chk("full2", chan_full[2], 1);
        cycle(0, 0, 0, 0, 4'b0);
        chk("c0_enq_rdy_while_c2_full", act_enq_rdy, 1);
        obs.delete();
        repeat (D + 2) cycle(0, 0, 0, 1, 4'b0);
        chk_obs("drain2", '{32'hA0, 32'hA1, 32'hA2, 32'hA3});

        // Reset mid-stream
        cycle(1, 1, 32'h01, 0, 4'b0);
        cycle(1, 1, 32'h02, 1, 4'b0);
        cycle(1, 0, 32'h03, 1, 4'b0);
        do_reset(1);
        cycle(0, 0, 0, 0, 4'b0);
        chk("post_reset_deq_val", act_deq_val, 0);

        // Round-robin interleave across chans 0,1,3
        cycle(1, 0, 32'h10, 0, 4'b0);
        cycle(1, 1, 32'h20, 0, 4'b0);
        cycle(1, 3, 32'h30, 0, 4'b0);
        cycle(1, 0, 32'h11, 0, 4'b0);
        cycle(1, 1, 32'h21, 0, 4'b0);
        cycle(1, 3, 32'h31, 0, 4'b0);
        obs.delete();
        repeat (8) cycle(0, 0, 0, 1, 4'b0);
        chk_obs("rr", '{32'h10, 32'h20, 32'h30, 32'h11, 32'h21, 32'h31});

        // Stall: grant on chan 1 must hold even when chan 0 becomes eligible
        cycle(1, 1, 32'h41, 0, 4'b0);
        cycle(1, 1, 32'h42, 0, 4'b0);
        cycle(1, 0, 32'h40, 0, 4'b0);
        chk("stall_chan_0", deq_chan, 1);
        for (int i = 1; i < 5; i++) begin
            cycle(0, 0, 0, 0, 4'b0);
            chk($sformatf("stall_chan_%0d", i), deq_chan, 1);
            chk($sformatf("stall_msg_%0d", i), deq_msg, 32'h41);
        end
        obs.delete();
        repeat (5) cycle(0, 0, 0, 1, 4'b0);
        chk_obs("stall_drain", '{32'h41, 32'h40, 32'h42});

        // PIPE: enqueue into full, granted, dequeuing channel
        for (int i = 0; i < D; i++) cycle(1, 1, 32'h60 + i, 0, 4'b0);
        obs.delete();
        cycle(1, 1, 32'h55, 1, 4'b0);
        chk("pipe_enq_rdy", act_enq_rdy, 1);
        cycle(0, 0, 0, 0, 4'b0);
        chk("pipe_count", cnt_of(1), 4);
        repeat (D + 2) cycle(0, 0, 0, 1, 4'b0);
        chk_obs("pipe", '{32'h60, 32'h61, 32'h62, 32'h63, 32'h55});

        // Flush a granted channel holding 3 entries
        for (int i = 0; i < 3; i++) cycle(1, 3, 32'h70 + i, 0, 4'b0);
        cycle(1, 3, 32'h99, 1, 4'b1000);
        chk("flush_deq_val", act_deq_val, 0);
        chk("flush_enq_rdy", act_enq_rdy, 0);
        cycle(0, 0, 0, 0, 4'b0);
        chk("flush_count3", cnt_of(3), 0);
        obs.delete();
        cycle(1, 3, 32'h77, 0, 4'b0);
        repeat (3) cycle(0, 0, 0, 1, 4'b0);
        chk_obs("post_flush", '{32'h77});

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            fl = 4'b0;
            for (int c = 0; c < NCH; c++) if ($urandom_range(0, 49) == 0) fl[c] = 1'b1;
            cycle($urandom_range(0, 99) < 60, int'($urandom_range(0, NCH - 1)), $urandom,
                  $urandom_range(0, 99) < 65, fl);
            if (n == 400) do_reset(1);
        end

        cycle(0, 0, 0, 0, 4'b1111);
        cycle(0, 0, 0, 1, 4'b0);
        cycle(0, 0, 0, 0, 4'b0);
        chk("scoreboard_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
